// File: rtl/mem_access_pkg.sv
// +-----------------------------------------------------------------------------+
// | mem_access_pkg                                                              |
// | Shared types for the memory-access stage: FSM states, access sizes, byte    |
// | strobe constants and the decoded one-hot instruction flag struct.           |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_t;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  // Decoded RV32I instruction, one flag per instruction, at most one set.
  typedef struct packed {
    logic lui, auipc, jal, jalr;
    logic beq, bne, blt, bge, bltu, bgeu;
    logic lb, lh, lw, lbu, lhu;
    logic sb, sh, sw;
    logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
    logic add, sub, sll, slt, sltu, xor_op, srl, sra, or_op, and_op;
    logic fence, ecall, ebreak;
  } instructions;

  function automatic mem_size_t op_size(input instructions i);
    if (i.lb || i.lbu || i.sb)      return SZ_B;
    else if (i.lh || i.lhu || i.sh) return SZ_H;
    else                            return SZ_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_load_extract.sv
// +-----------------------------------------------------------------------------+
// | load_extract                                                                |
// | Combinational load lane selection with sign/zero extension.                 |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module load_extract
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  mem_size_t   size,
  input  logic        uns,
  output logic [31:0] value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (a)
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      2'd3:    w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
    // Halfword select ignores a[0]; misaligned halves never reach here trapped.
    w_half = a[1] ? rdata[31:16] : rdata[15:0];

    value = rdata;
    case (size)
      SZ_B:    value = {{24{~uns & w_byte[7]}}, w_byte};
      SZ_H:    value = {{16{~uns & w_half[15]}}, w_half};
      default: value = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// +-----------------------------------------------------------------------------+
// | mem_access                                                                  |
// | RV32I memory stage: single-outstanding req/ack data port, store lane        |
// | steering, load extension, registered result with a one-cycle completed.     |
// | Optional: MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses.         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  instructions       instr,
  input  logic              enabled,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       rs2_v,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       result,
  output logic              completed,
  output logic              busy,
  output logic              misaligned
);

  if (DATA_W != 32 || ADDR_W < 3 || ADDR_W > 32) begin : g_param_check
    $error("mem_access: DATA_W must be 32 and ADDR_W in 3..32");
  end

  mem_state_t        r_state, w_state_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_result;
  logic              r_misaligned;
  logic [1:0]        r_a_lo;
  mem_size_t         r_size;
  logic              r_uns;

  logic        w_is_load, w_is_store, w_mem, w_valid, w_accept, w_misalign;
  mem_size_t   w_size;
  logic [31:0] w_wdata, w_load_val;
  logic [3:0]  w_wstrb;

  assign w_is_load  = instr.lb | instr.lh | instr.lw | instr.lbu | instr.lhu;
  assign w_is_store = instr.sb | instr.sh | instr.sw;
  assign w_mem      = w_is_load | w_is_store;
  // An enable with no decoded flag is a bubble and is not accepted.
  assign w_valid    = |instr;
  assign w_accept   = (r_state == IDLE) & enabled & w_valid;
  assign w_size     = op_size(instr);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = w_mem & (((w_size == SZ_H) & alu_result[0]) |
                               ((w_size == SZ_W) & (|alu_result[1:0])));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_wdata = rs2_v;
    w_wstrb = STRB_W;
    case (w_size)
      SZ_B: begin
        w_wdata = {4{rs2_v[7:0]}};
        w_wstrb = STRB_B << alu_result[1:0];
      end
      SZ_H: begin
        w_wdata = {2{rs2_v[15:0]}};
        w_wstrb = STRB_H << {alu_result[1], 1'b0};
      end
      default: begin
        w_wdata = rs2_v;
        w_wstrb = STRB_W;
      end
    endcase
  end

  load_extract u_load_extract (
    .rdata (mem_rdata),
    .a     (r_a_lo),
    .size  (r_size),
    .uns   (r_uns),
    .value (w_load_val)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = (w_mem & ~w_misalign) ? REQ : DONE;
      REQ:     if (mem_ack) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_result     <= '0;
      r_misaligned <= 1'b0;
      r_a_lo       <= '0;
      r_size       <= SZ_W;
      r_uns        <= 1'b0;
    end else if (w_accept) begin
      r_misaligned <= w_misalign;
      if (w_mem & ~w_misalign) begin
        r_we    <= w_is_store;
        r_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
        r_wdata <= w_wdata;
        r_wstrb <= w_is_store ? w_wstrb : 4'b0000;
        r_a_lo  <= alu_result[1:0];
        r_size  <= w_size;
        r_uns   <= instr.lbu | instr.lhu;
      end else begin
        r_result <= w_misalign ? 32'd0 : alu_result;
      end
    end else if ((r_state == REQ) && mem_ack) begin
      r_result <= r_we ? 32'd0 : w_load_val;
    end
  end

  assign mem_req    = (r_state == REQ);
  assign busy       = (r_state == REQ);
  assign completed  = (r_state == DONE);
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_wstrb  = r_wstrb;
  assign result     = r_result;
  assign misaligned = r_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// +-----------------------------------------------------------------------------+
// | tb_mem_access                                                               |
// | Randomized scoreboard bench for mem_access with a reactive memory model.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  instructions instr = '0;
  logic        enabled = 1'b0;
  logic [31:0] alu_result = '0, rs2_v = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req, mem_we, completed, busy, misaligned;
  logic [31:0] mem_addr, mem_wdata, result;
  logic [3:0]  mem_wstrb;

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn), .instr(instr), .enabled(enabled),
    .alu_result(alu_result), .rs2_v(rs2_v), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .result(result),
    .completed(completed), .busy(busy), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef enum int {K_ADDI, K_LB, K_LH, K_LW, K_LBU, K_LHU, K_SB, K_SH, K_SW} kind_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } req_t;
  typedef struct { logic [31:0] res; logic mis; } rsp_t;

  req_t        req_q[$];
  rsp_t        rsp_q[$];
  int          delay_q[$];
  logic [31:0] rdata_q[$];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: lane arithmetic straight from the address/size rules.
  function automatic logic [31:0] ref_load(input kind_t k, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    int off;
    off = int'(a % 32'd4);
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * int'((a / 32'd2) % 32'd2))) & 32'hFFFF;
    case (k)
      K_LB:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      K_LH:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      K_LBU:   return b;
      K_LHU:   return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic ref_mis(input kind_t k, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (k == K_LH || k == K_LHU || k == K_SH) return (a % 32'd2) != 0;
    if (k == K_LW || k == K_SW)               return (a % 32'd4) != 0;
`endif
    return (k == K_ADDI) && (a != a);
  endfunction

  function automatic req_t ref_req(input kind_t k, input logic [31:0] a, input logic [31:0] rs2);
    req_t r;
    r.addr = a - (a % 32'd4);
    r.we = (k == K_SB || k == K_SH || k == K_SW);
    r.wstrb = 4'd0;
    r.wdata = 32'd0;
    case (k)
      K_SB: begin r.wstrb = 4'(1 << int'(a % 32'd4));               r.wdata = (rs2 & 32'hFF) * 32'h0101_0101; end
      K_SH: begin r.wstrb = 4'(3 << (2 * int'((a / 32'd2) % 32'd2))); r.wdata = (rs2 & 32'hFFFF) * 32'h0001_0001; end
      K_SW: begin r.wstrb = 4'd15; r.wdata = rs2; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic drive(input kind_t k, input logic [31:0] a, input logic [31:0] rs2);
    instr = '0;
    case (k)
      K_ADDI: instr.addi = 1'b1;
      K_LB:   instr.lb = 1'b1;
      K_LH:   instr.lh = 1'b1;
      K_LW:   instr.lw = 1'b1;
      K_LBU:  instr.lbu = 1'b1;
      K_LHU:  instr.lhu = 1'b1;
      K_SB:   instr.sb = 1'b1;
      K_SH:   instr.sh = 1'b1;
      default: instr.sw = 1'b1;
    endcase
    alu_result = a;
    rs2_v = rs2;
    enabled = 1'b1;
    @(posedge clk); #1;
    enabled = 1'b0;
    instr = '0;
    alu_result = $urandom;
    rs2_v = $urandom;
  endtask

  task automatic do_op(input kind_t k, input logic [31:0] a, input logic [31:0] rs2,
                       input logic [31:0] rd, input int dly);
    logic mem, st, mis;
    int lat, exp_lat;
    rsp_t rsp;
    mem = (k != K_ADDI);
    st = (k == K_SB || k == K_SH || k == K_SW);
    mis = ref_mis(k, a);
    if (mem && !mis) begin
      req_q.push_back(ref_req(k, a, rs2));
      delay_q.push_back(dly);
      rdata_q.push_back(rd);
    end
    rsp.mis = mis;
    rsp.res = mis ? 32'd0 : (!mem ? a : (st ? 32'd0 : ref_load(k, a, rd)));
    rsp_q.push_back(rsp);
    exp_lat = (mem && !mis) ? 2 + dly : 1;
    drive(k, a, rs2);
    lat = 1;
    while (!completed && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  // Reactive memory: checks each request on its first cycle and for stability.
  bit          in_req = 1'b0;
  int          cnt = 0, cur_dly = 0;
  req_t        cur;
  logic [31:0] cur_rd;

  always @(negedge clk) begin
    if (!mem_req) begin
      in_req = 1'b0;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end else begin
      if (!in_req) begin
        in_req = 1'b1;
        cnt = 0;
        if (req_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req: got mem_req=1 at addr 0x%08h expected no request", mem_addr);
          cur = '{1'b0, mem_addr, mem_wdata, mem_wstrb};
          cur_dly = 0; cur_rd = 32'd0;
        end else begin
          cur = req_q.pop_front();
          cur_dly = delay_q.pop_front();
          cur_rd = rdata_q.pop_front();
          check("req_addr", mem_addr, cur.addr);
          check("req_we", 32'(mem_we), 32'(cur.we));
          check("req_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
          if (cur.we) check("req_wdata", mem_wdata, cur.wdata);
        end
      end else begin
        cnt++;
        check("req_stable_addr", mem_addr, cur.addr);
        check("req_stable_strb", 32'(mem_wstrb), 32'(cur.wstrb));
        if (cnt > cur_dly) check("req_after_ack", 32'(mem_req), 32'd0);
      end
      mem_ack = (cnt == cur_dly);
      mem_rdata = (cnt == cur_dly) ? cur_rd : $urandom;
    end
  end

  // Monitor: pops the scoreboard on every completion pulse.
  logic [31:0] last_result = 32'd0;
  always @(negedge clk) begin
    if (!rstn) begin
      last_result = 32'd0;
    end else if (completed) begin
      if (rsp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_completed: got completed=1 result=0x%08h expected none", result);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        check("result", result, e.res);
        check("misaligned", 32'(misaligned), 32'(e.mis));
      end
      last_result = result;
    end else begin
      check("result_hold", result, last_result);
    end
  end

  always @(posedge clk)
    if (enabled) assert ($countones(instr) <= 1) else $error("more than one instr flag set");

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_completed", 32'(completed), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_result", result, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    do_op(K_ADDI, 32'h0000_002A, 32'h0, 32'h0, 0);
    do_op(K_LB,   32'h0000_1003, 32'h0, 32'h80FF_0000, 0);
    do_op(K_LHU,  32'h0000_2002, 32'h0, 32'hBEEF_1234, 3);
    do_op(K_SB,   32'h0000_3001, 32'h1234_56AB, 32'h0, 1);
    do_op(K_LW,   32'h0000_4002, 32'h0, 32'hCAFE_F00D, 0);
    do_op(K_SH,   32'h0000_5003, 32'hDEAD_BEEF, 32'h0, 2);

    // Reset while a store is waiting for a late ack.
    req_q.push_back(ref_req(K_SW, 32'h0000_6004, 32'h0BAD_F00D));
    delay_q.push_back(40);
    rdata_q.push_back(32'h0);
    drive(K_SW, 32'h0000_6004, 32'h0BAD_F00D);
    @(posedge clk); @(posedge clk); #2;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("async_rst_mem_req", 32'(mem_req), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_completed", 32'(completed), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    do_op(K_ADDI, 32'h1357_9BDF, 32'h0, 32'h0, 0);

    for (int i = 0; i < 300; i++) begin
      do_op(kind_t'($urandom_range(0, 8)), $urandom, $urandom, $urandom, int'($urandom_range(0, 4)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(rsp_q.size()), 32'd0);
    check("requests_drained", 32'(req_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
